// File: rtl/uart_pkg.sv
// Shared FSM state type, parity-mode encoding and bit-timing/parity helpers
// for the FIFO-fed UART transmitter.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

  // Payload is zero-extended to 9 bits; the padding does not change the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic p;
    p = ^data;
    if (mode == PARITY_ODD) begin
      return ~p;
    end else begin
      return p;
    end
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with occupancy count; pushes are refused when full and
// pops are ignored when empty.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           push_data_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           pop_data_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             push_s;
  logic             pop_s;

  assign full_o     = (count_q == (AW+1)'(DEPTH));
  assign empty_o    = (count_q == (AW+1)'(0));
  assign push_s     = push_i && !full_o;
  assign pop_s      = pop_i && !empty_o;
  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

  // Storage is not reset: pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= (AW+1)'(0);
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a word FIFO: start bit, LSB-first payload, optional
// parity and one or two stop bits, with back-to-back frames while words remain.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_valid,
  input  logic [DATA_BITS-1:0]          tx_data,
  output logic                          tx_ready,
  output logic                          tx_serial,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_empty
);

  localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_fifo: DATA_BITS must be in 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_fifo: FIFO_DEPTH must be a power of two, at least 2");
  end
  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  uart_state_e            state_q;
  logic [CNT_W-1:0]       baud_cnt_q;
  logic [3:0]             bit_cnt_q;
  logic [DATA_BITS-1:0]   shift_q;
  logic                   par_q;
  logic                   tx_serial_q;
  logic                   tx_busy_q;

  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic [DATA_BITS-1:0]   fifo_rd_data_s;
  logic                   bit_end_s;
  logic                   last_stop_s;
  logic                   pop_s;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (tx_valid),
    .push_data_i (tx_data),
    .pop_i       (pop_s),
    .pop_data_o  (fifo_rd_data_s),
    .count_o     (fifo_count),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  assign tx_ready   = !fifo_full_s;
  assign fifo_empty = fifo_empty_s;
  assign tx_serial  = tx_serial_q;
  assign tx_busy    = tx_busy_q;

  assign bit_end_s   = (baud_cnt_q == CNT_W'(CPB - 1));
  assign last_stop_s = (state_q == STOP) && bit_end_s && (bit_cnt_q == 4'(STOP_BITS - 1));
  // A word is taken from an idle line, or at the end of the final stop bit for zero-gap chaining.
  assign pop_s       = !fifo_empty_s && ((state_q == IDLE) || last_stop_s);

  // Frame sequencer; the line and busy flag are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      baud_cnt_q  <= CNT_W'(0);
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tx_serial_q <= 1'b1;
      tx_busy_q   <= 1'b0;
    end else if (pop_s) begin
      state_q     <= START;
      baud_cnt_q  <= CNT_W'(0);
      bit_cnt_q   <= 4'd0;
      shift_q     <= fifo_rd_data_s;
      par_q       <= parity_bit(9'(fifo_rd_data_s), PARITY);
      tx_serial_q <= 1'b0;
      tx_busy_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          baud_cnt_q  <= CNT_W'(0);
          bit_cnt_q   <= 4'd0;
          tx_serial_q <= 1'b1;
          tx_busy_q   <= 1'b0;
        end
        START: begin
          if (bit_end_s) begin
            baud_cnt_q  <= CNT_W'(0);
            bit_cnt_q   <= 4'd0;
            state_q     <= DATA;
            tx_serial_q <= shift_q[0];
            shift_q     <= {1'b0, shift_q[DATA_BITS-1:1]};
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (bit_end_s) begin
            baud_cnt_q <= CNT_W'(0);
            if (bit_cnt_q == 4'(DATA_BITS - 1)) begin
              bit_cnt_q <= 4'd0;
              if (PARITY != PARITY_NONE) begin
                state_q     <= PAR;
                tx_serial_q <= par_q;
              end else begin
                state_q     <= STOP;
                tx_serial_q <= 1'b1;
              end
            end else begin
              bit_cnt_q   <= bit_cnt_q + 4'd1;
              tx_serial_q <= shift_q[0];
              shift_q     <= {1'b0, shift_q[DATA_BITS-1:1]};
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        PAR: begin
          if (bit_end_s) begin
            baud_cnt_q  <= CNT_W'(0);
            bit_cnt_q   <= 4'd0;
            state_q     <= STOP;
            tx_serial_q <= 1'b1;
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (bit_end_s) begin
            baud_cnt_q <= CNT_W'(0);
            if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
              bit_cnt_q   <= 4'd0;
              state_q     <= IDLE;
              tx_serial_q <= 1'b1;
              tx_busy_q   <= 1'b0;
            end else begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q     <= IDLE;
          baud_cnt_q  <= CNT_W'(0);
          bit_cnt_q   <= 4'd0;
          tx_serial_q <= 1'b1;
          tx_busy_q   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Five transmitter instances (8N1 x2, 8E1, 8O1, 7N2) driven in parallel; a line
// monitor per instance checks every bit window against a queue of expected frames.
module tb_uart_tx_fifo;

  localparam int CPB = 434;
  localparam int N   = 5;

  typedef struct {
    logic [11:0] fr;
    int          nb;
  } exp_t;

  typedef struct {
    int          inst;
    logic [8:0]  data;
    logic [11:0] fr;
    int          nb;
  } vec_t;

  logic                clk = 1'b0;
  logic [N-1:0]        rst;
  logic [N-1:0]        valid;
  logic [N-1:0]        ser;
  logic [N-1:0]        busy;
  logic [N-1:0]        ready;
  logic [N-1:0]        empty;
  logic [N-1:0]        mon_en;
  logic [N-1:0][8:0]   din;
  logic [N-1:0][4:0]   cnt;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];
  exp_t q3[$];
  exp_t q4[$];
  int   n_exp[N];
  int   n_done[N];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_n81 (
    .clk(clk), .rst(rst[0]), .tx_valid(valid[0]), .tx_data(din[0][7:0]), .tx_ready(ready[0]),
    .tx_serial(ser[0]), .tx_busy(busy[0]), .fifo_count(cnt[0]), .fifo_empty(empty[0]));

  uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_full (
    .clk(clk), .rst(rst[1]), .tx_valid(valid[1]), .tx_data(din[1][7:0]), .tx_ready(ready[1]),
    .tx_serial(ser[1]), .tx_busy(busy[1]), .fifo_count(cnt[1]), .fifo_empty(empty[1]));

  uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(2),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_e81 (
    .clk(clk), .rst(rst[2]), .tx_valid(valid[2]), .tx_data(din[2][7:0]), .tx_ready(ready[2]),
    .tx_serial(ser[2]), .tx_busy(busy[2]), .fifo_count(cnt[2]), .fifo_empty(empty[2]));

  uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(1),
                 .STOP_BITS(1), .FIFO_DEPTH(16)) u_o81 (
    .clk(clk), .rst(rst[3]), .tx_valid(valid[3]), .tx_data(din[3][7:0]), .tx_ready(ready[3]),
    .tx_serial(ser[3]), .tx_busy(busy[3]), .fifo_count(cnt[3]), .fifo_empty(empty[3]));

  uart_tx_fifo #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200), .DATA_BITS(7), .PARITY(0),
                 .STOP_BITS(2), .FIFO_DEPTH(16)) u_n72 (
    .clk(clk), .rst(rst[4]), .tx_valid(valid[4]), .tx_data(din[4][6:0]), .tx_ready(ready[4]),
    .tx_serial(ser[4]), .tx_busy(busy[4]), .fifo_count(cnt[4]), .fifo_empty(empty[4]));

  function automatic logic [11:0] frame8(input logic [7:0] d);
    return {3'b000, 1'b1, d, 1'b0};
  endfunction

  function automatic int q_size(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      3: return q3.size();
      4: return q4.size();
      default: return 0;
    endcase
  endfunction

  task automatic push_exp(input int i, input logic [11:0] fr, input int nb);
    exp_t e;
    e.fr = fr;
    e.nb = nb;
    case (i)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      3: q3.push_back(e);
      4: q4.push_back(e);
      default: ;
    endcase
    n_exp[i]++;
  endtask

  task automatic pop_exp(input int i, output exp_t e);
    case (i)
      0: e = q0.pop_front();
      1: e = q1.pop_front();
      2: e = q2.pop_front();
      3: e = q3.pop_front();
      default: e = q4.pop_front();
    endcase
  endtask

  task automatic chk(input string name, input int inst, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst=%0d actual=%0h required=%0h", name, inst, act, exp);
    end
  endtask

  // Entered on the first low sample of a start bit; each bit must hold for exactly CPB clocks.
  task automatic check_frame(input int i, output bit started);
    exp_t e;
    logic seen;
    if (q_size(i) == 0) begin
      checks++;
      failures++;
      $display("FAIL unexpected_frame inst=%0d actual=start_bit required=idle_line", i);
      repeat (12 * CPB) @(negedge clk);
      started = 1'b0;
      return;
    end
    pop_exp(i, e);
    for (int b = 0; b < e.nb; b++) begin
      seen = e.fr[b];
      for (int c = 0; c < CPB; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if (ser[i] !== e.fr[b]) seen = ser[i];
      end
      chk($sformatf("frame_bit%0d", b), i, 32'(seen), 32'(e.fr[b]));
    end
    n_done[i]++;
    @(negedge clk);
    if (q_size(i) > 0) begin
      chk("b2b_start_low", i, 32'(ser[i]), 32'd0);
    end else begin
      chk("end_line_high", i, 32'(ser[i]), 32'd1);
      chk("end_busy_low", i, 32'(busy[i]), 32'd0);
    end
    started = (ser[i] === 1'b0);
  endtask

  task automatic monitor(input int i);
    bit pend;
    pend = 1'b0;
    forever begin
      if (!pend) @(negedge clk);
      pend = 1'b0;
      if (mon_en[i] && ser[i] === 1'b0) check_frame(i, pend);
    end
  endtask

  task automatic drive(input int i, input logic [8:0] d);
    valid[i] = 1'b1;
    din[i]   = d;
    @(posedge clk);
    #1;
    valid[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int budget);
    int k;
    k = 0;
    while (n_done[i] != n_exp[i] && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (n_done[i] != n_exp[i]) begin
      checks++;
      failures++;
      $display("FAIL wait_done inst=%0d actual_frames=%0d required=%0d", i, n_done[i], n_exp[i]);
    end
  endtask

  initial begin
    fork
      monitor(0);
      monitor(1);
      monitor(2);
      monitor(3);
      monitor(4);
    join
  end

  initial begin
    vec_t tbl[6];
    tbl[0] = '{0, 9'h0A5, 12'h34A, 10};
    tbl[1] = '{2, 9'h0A5, 12'h54A, 11};
    tbl[2] = '{2, 9'h001, 12'h602, 11};
    tbl[3] = '{3, 9'h0A5, 12'h74A, 11};
    tbl[4] = '{4, 9'h07F, 12'h3FE, 10};
    tbl[5] = '{4, 9'h02A, 12'h354, 10};

    rst    = '1;
    valid  = '0;
    din    = '0;
    mon_en = '1;
    for (int i = 0; i < N; i++) begin
      n_exp[i]  = 0;
      n_done[i] = 0;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      chk("rst_serial", i, 32'(ser[i]), 32'd1);
      chk("rst_busy", i, 32'(busy[i]), 32'd0);
      chk("rst_count", i, 32'(cnt[i]), 32'd0);
      chk("rst_empty", i, 32'(empty[i]), 32'd1);
      chk("rst_ready", i, 32'(ready[i]), 32'd1);
    end
    @(negedge clk);
    rst = '0;
    @(posedge clk);
    #1;

    for (int v = 0; v < 6; v++) begin
      push_exp(tbl[v].inst, tbl[v].fr, tbl[v].nb);
      drive(tbl[v].inst, tbl[v].data);
    end

    // Fill while a lead frame occupies the line so nothing drains during the burst.
    push_exp(1, frame8(8'h55), 10);
    drive(1, 9'h055);
    repeat (3) @(posedge clk);
    #1;
    chk("full_lead_popped", 1, 32'(cnt[1]), 32'd0);
    chk("full_lead_busy", 1, 32'(busy[1]), 32'd1);
    for (int k = 0; k < 17; k++) begin
      chk($sformatf("full_ready_k%0d", k), 1, 32'(ready[1]), (k < 16) ? 32'd1 : 32'd0);
      chk($sformatf("full_count_k%0d", k), 1, 32'(cnt[1]), 32'(k));
      if (k < 16) push_exp(1, frame8(8'(k)), 10);
      drive(1, 9'(k));
    end
    chk("full_ready_after", 1, 32'(ready[1]), 32'd0);
    chk("full_count_after", 1, 32'(cnt[1]), 32'd16);

    wait_done(0, 6000);
    repeat (200) @(posedge clk);
    #1;
    chk("n81_idle_line", 0, 32'(ser[0]), 32'd1);
    chk("n81_idle_busy", 0, 32'(busy[0]), 32'd0);

    push_exp(0, frame8(8'h3C), 10);
    drive(0, 9'h03C);
    chk("sim_count_first", 0, 32'(cnt[0]), 32'd1);
    push_exp(0, frame8(8'hC3), 10);
    drive(0, 9'h0C3);
    chk("sim_count_hold", 0, 32'(cnt[0]), 32'd1);
    chk("sim_busy", 0, 32'(busy[0]), 32'd1);
    wait_done(0, 10000);

    mon_en[0] = 1'b0;
    drive(0, 9'h000);
    drive(0, 9'h011);
    chk("rst_frame_start", 0, 32'(ser[0]), 32'd0);
    repeat (4 * CPB + CPB / 2) @(posedge clk);
    #1;
    chk("rst_bit3_low", 0, 32'(ser[0]), 32'd0);
    chk("rst_pre_count", 0, 32'(cnt[0]), 32'd1);
    #2;
    rst[0] = 1'b1;
    #1;
    chk("midrst_serial", 0, 32'(ser[0]), 32'd1);
    chk("midrst_busy", 0, 32'(busy[0]), 32'd0);
    chk("midrst_count", 0, 32'(cnt[0]), 32'd0);
    chk("midrst_empty", 0, 32'(empty[0]), 32'd1);
    chk("midrst_ready", 0, 32'(ready[0]), 32'd1);
    @(posedge clk);
    #1;
    chk("midrst_hold_line", 0, 32'(ser[0]), 32'd1);
    @(negedge clk);
    rst[0]    = 1'b0;
    mon_en[0] = 1'b1;
    push_exp(0, frame8(8'h5A), 10);
    drive(0, 9'h05A);
    chk("post_rst_push", 0, 32'(cnt[0]), 32'd1);

    for (int i = 0; i < N; i++) begin
      wait_done(i, 80000);
      chk("frames_seen", i, 32'(n_done[i]), 32'(n_exp[i]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200, meaning the serial bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8, meaning the payload width; legal values are 5 to 9.
REQ-004 SHALL have parameter PARITY, default 0, meaning 0=none, 1=odd, 2=even.
REQ-005 SHALL have parameter STOP_BITS, default 1, meaning the stop-bit count; legal values are 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 16, meaning the number of queued words; power of 2, at least 2.
REQ-007 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-009 SHALL have port tx_valid, input, 1 bit: the write-side word-valid strobe.
REQ-010 SHALL have port tx_data, input, DATA_BITS wide: the word to queue.
REQ-011 SHALL have port tx_ready, output, 1 bit: high when the FIFO can accept a word (not full).
REQ-012 SHALL have port tx_serial, output, 1 bit: the serial line; idles high.
REQ-013 SHALL have port tx_busy, output, 1 bit: high while a frame is on the line.
REQ-014 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH)+1 bits: the number of queued words.
REQ-015 SHALL have port fifo_empty, output, 1 bit: high when fifo_count is 0.

Function
REQ-016 SHALL define CLKS_PER_BIT = CLK_FREQ/BAUD_RATE with integer truncation; every line bit lasts exactly CLKS_PER_BIT clocks.
REQ-017 SHALL write tx_data into the FIFO on any cycle with tx_valid=1 and tx_ready=1.
REQ-018 SHALL ignore tx_valid when the FIFO is full (tx_ready=0), with no overwrite and no count change.
REQ-019 SHALL pop a word the cycle after IDLE sees fifo_empty=0, then enter START.
REQ-020 SHALL handle a simultaneous push and pop by leaving fifo_count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-021 SHALL use FSM states IDLE, START, DATA, PAR, STOP.
REQ-022 SHALL sequence the FSM as IDLE->START->DATA (DATA_BITS bits)->PAR (only if PARITY!=0)->STOP (STOP_BITS bits)->IDLE.
REQ-023 SHALL drive tx_serial to 1 in IDLE, 0 in START, and data LSB first in DATA.
REQ-024 SHALL drive the parity bit so that odd parity gives XOR(data)^1 and even parity gives XOR(data).
REQ-025 SHALL drive 1 in STOP.
REQ-026 SHALL, with a non-empty FIFO at the end of STOP, go STOP->START directly with zero idle clocks between frames.
REQ-027 SHALL assert tx_busy in START, DATA, PAR and STOP, and deassert it in IDLE.
REQ-028 SHALL register tx_serial and tx_busy, with no combinational path from tx_valid.
REQ-029 SHALL compute the frame length as 1+DATA_BITS+(PARITY!=0)+STOP_BITS bits.

Reset
REQ-030 SHALL, on rst=1, immediately set tx_serial=1, tx_busy=0, state=IDLE, fifo_count=0, fifo_empty=1, tx_ready=1, with bit and baud counters at 0.
REQ-031 SHALL, on reset mid-frame, abort the frame, discard queued words, and return tx_serial high with no glitch low.
REQ-032 SHALL, after rst deasserts, accept a push on the first rising edge.

Structure
REQ-033 SHALL place in package uart_pkg: the state enum typedef, the parity-mode constants, and a clks_per_bit function.
REQ-034 SHALL implement the FIFO as sub-module uart_sync_fifo, parameterised by width and depth, with count/full/empty outputs.
REQ-035 SHALL error at elaboration on illegal DATA_BITS, PARITY, STOP_BITS, FIFO_DEPTH, or CLKS_PER_BIT<2.

Verification (CLK_FREQ=50_000_000, BAUD_RATE=115200, CLKS_PER_BIT=434)
REQ-036 SHALL cover 8N1: push 0xA5 -> line shows 0,1,0,1,0,0,1,0,1,1, each 434 clocks, for 4340 clocks total; tx_busy drops and the line stays high.
REQ-037 SHALL cover 8E1 and 8O1: push 0xA5 -> parity bit is 0 (even) and 1 (odd); frame is 4774 clocks.
REQ-038 SHALL cover FIFO full: push 17 words 0x00..0x10 back-to-back with depth 16 -> tx_ready=0 at the full point and the refused word is absent; the sent words are exactly those accepted, in order, with no idle gap between frames.
REQ-039 SHALL cover 7-bit, 2-stop, no parity: push 0x7F -> frame 0,1x7,1,1 lasting 10x434 clocks.
REQ-040 SHALL cover reset mid-frame: assert rst during DATA bit 3 -> tx_serial=1, tx_busy=0, fifo_count=0 the same cycle.
REQ-041 SHALL cover simultaneous push and pop at count 1 -> fifo_count stays 1 and the next frame carries the pushed word.
